boot_copier: RTL and testbench
==============================

# boot_copier

Boot-time sequencer that sits directly downstream of the 512 x 32 boot PROM. It steps the PROM address, captures each word after the PROM's one-cycle registered read, and writes it into main memory through a write/acknowledge handshake. The CPU is held in reset until the copy completes. A running 32-bit checksum of the copied image is provided for the RTS watchdog/diagnostics.

## Interface
- WORDS, 512: number of words copied; 1..512.
- DST_BASE, 0: word address in main memory of the first destination word.
- AW, 24: main-memory word-address width.

- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a copy when in IDLE or DONE.
- prom_addr  out  9  registered PROM word address.
- prom_data  in  32  PROM output, valid the cycle after prom_addr was sampled.
- mem_addr  out  AW  registered destination word address.
- mem_wdata  out  32  registered write data.
- mem_wr  out  1  write request; held until acknowledged.
- mem_ack  in  1  memory accepts the write in any cycle where mem_wr and mem_ack are both high.
- busy  out  1  high in FETCH, LATCH, WRITE.
- done  out  1  high in DONE; sticky until next start or rst.
- cpu_hold  out  1  CPU reset hold; high in every state except DONE.
- checksum  out  32  sum mod 2^32 of words written in the current or last copy.

## Operation
- States: IDLE, FETCH, LATCH, WRITE, DONE. Internal index idx, 9 bits.
- IDLE: on start=1, idx<=0, prom_addr<=0, checksum<=0, go to FETCH. Otherwise stay.
- FETCH: prom_addr holds idx; the PROM samples it on this edge. Go to LATCH.
- LATCH: prom_data is valid. mem_wdata<=prom_data, mem_addr<=DST_BASE+idx (zero-extended, wraps mod 2^AW), mem_wr<=1, checksum<=checksum+prom_data. Go to WRITE.
- WRITE: mem_wr, mem_addr, mem_wdata stable until a cycle with mem_ack=1. On that edge mem_wr<=0, then:
  - if idx==WORDS-1, go to DONE;
  - else idx<=idx+1, prom_addr<=idx+1, go to FETCH.
- DONE: done=1, cpu_hold=0. On start=1, behave as in IDLE (re-copy; checksum cleared, cpu_hold reasserts).
- start in FETCH/LATCH/WRITE is ignored.
- mem_ack outside WRITE is ignored. mem_ack coinciding with the entry into WRITE does not count; the ack must be sampled while mem_wr=1.
- Checksum arithmetic is unsigned 32-bit with wrap-around. It updates once per word, in LATCH.

## Timing
- Reset values: state=IDLE, idx=0, prom_addr=0, mem_addr=0, mem_wdata=0, mem_wr=0, busy=0, done=0, cpu_hold=1, checksum=0.
- rst at any time, including mid-write, returns immediately to the reset values. The aborted write is dropped: mem_wr falls asynchronously.
- With mem_ack tied high, each word takes 3 cycles (FETCH, LATCH, WRITE).
- The start edge is followed by 3*WORDS cycles, then DONE. done rises and cpu_hold falls on the edge after the last ack.
- Each wait cycle on mem_ack adds exactly one cycle.
- Write requests are spaced by at least 2 idle cycles (mem_wr=0 in FETCH and LATCH).
- busy, done, and cpu_hold are decoded from the registered state, with no combinational path from inputs.

## Test plan
- Reset and idle:
  - Stimulus: assert rst mid-sim, with no start.
  - Required response: all outputs at reset values; prom_addr=0, cpu_hold=1, done=0 indefinitely.
- Full copy, zero wait:
  - Stimulus: PROM model preloaded with mem[i]=32'hA5000000+i, WORDS=512, DST_BASE=24'h000100, mem_ack=1, start pulse.
  - Required response: 512 writes to 0x100..0x2FF with matching data, in order; done after exactly 1536 cycles; checksum equals the model sum mod 2^32.
- Wait states:
  - Stimulus: WORDS=4; mem_ack random 0-3 cycle delays.
  - Required response: mem_wr/mem_addr/mem_wdata stable while stalled; exactly 4 writes, no duplicates; total cycles = 12 + total wait cycles.
- Reset mid-operation:
  - Stimulus: assert rst during WRITE of word 100 with mem_ack=0; later issue start.
  - Required response: mem_wr drops asynchronously; the copy restarts from prom_addr=0; checksum covers only the new pass.
- Ignored and repeated start:
  - Stimulus: pulse start during LATCH of word 5; after DONE, pulse start again.
  - Required response: the first extra start has no effect. The second start reasserts cpu_hold, clears done and checksum, and repeats an identical copy.
- Boundary:
  - Stimulus: WORDS=1; separately DST_BASE=2^AW-1 with WORDS=2.
  - Required response: a single write, then DONE after 3 cycles. For the second case, destination addresses wrap to 0xFFFFFF then 0x000000.

Source files
------------

// File: rtl/boot_copier_if.sv
// boot_copier_if: PROM read port, main-memory write handshake and status of the boot copier.
interface boot_copier_if #(
   parameter int AW = 24
);
   logic          start;
   logic [8:0]    prom_addr;
   logic [31:0]   prom_data;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          mem_wr;
   logic          mem_ack;
   logic          busy;
   logic          done;
   logic          cpu_hold;
   logic [31:0]   checksum;
   modport master (
      input  start, prom_data, mem_ack,
      output prom_addr, mem_addr, mem_wdata, mem_wr, busy, done, cpu_hold, checksum
   );
   modport slave (
      output start, prom_data, mem_ack,
      input  prom_addr, mem_addr, mem_wdata, mem_wr, busy, done, cpu_hold, checksum
   );
endinterface

// File: rtl/boot_copier.sv
// boot_copier: copies the boot PROM image into main memory word by word,
// holding the CPU in reset and accumulating a checksum until the copy completes.
module boot_copier #(
   parameter int            WORDS    = 512,
   parameter int            AW       = 24,
   parameter logic [AW-1:0] DST_BASE = '0
) (
   input logic           clk,
   input logic           rst,
   boot_copier_if.master bus
);
   typedef enum logic [2:0] {IDLE, FETCH, LATCH, WRITE, DONE} state_t;
   state_t     state, state_n;
   logic [8:0] idx;
   logic       last, go, acked;
   assign last  = idx == 9'(WORDS - 1);
   assign go    = (state == IDLE || state == DONE) && bus.start;
   assign acked = state == WRITE && bus.mem_ack;
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_n;
   always_comb begin
      state_n      = state;
      bus.busy     = 1'b0;
      bus.done     = 1'b0;
      bus.cpu_hold = 1'b1;
      case (state)
         IDLE:    state_n = bus.start ? FETCH : IDLE;
         FETCH:   begin state_n = LATCH; bus.busy = 1'b1; end
         LATCH:   begin state_n = WRITE; bus.busy = 1'b1; end
         WRITE:   begin state_n = !bus.mem_ack ? WRITE : last ? DONE : FETCH; bus.busy = 1'b1; end
         DONE:    begin state_n = bus.start ? FETCH : DONE; bus.done = 1'b1; bus.cpu_hold = 1'b0; end
         default: state_n = IDLE;
      endcase
   end
   // PROM data is sampled in LATCH, one cycle after FETCH presented the address
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         idx           <= '0;
         bus.prom_addr <= '0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.mem_wr    <= 1'b0;
         bus.checksum  <= '0;
      end else begin
         if (go) begin
            idx           <= '0;
            bus.prom_addr <= '0;
            bus.checksum  <= '0;
         end
         if (state == LATCH) begin
            bus.mem_wdata <= bus.prom_data;
            bus.mem_addr  <= DST_BASE + AW'(idx);
            bus.mem_wr    <= 1'b1;
            bus.checksum  <= bus.checksum + bus.prom_data;
         end
         if (acked) begin
            bus.mem_wr <= 1'b0;
            if (!last) begin
               idx           <= idx + 9'd1;
               bus.prom_addr <= idx + 9'd1;
            end
         end
      end
endmodule

// File: tb/tb_boot_copier.sv
// tb_boot_copier: four boot_copier configurations driven from a vector table plus hand-written
// reset/restart sequences, checked against a PROM-image reference model.
module tb_boot_copier;
   localparam int          NW[4] = '{512, 4, 1, 2};
   localparam logic [23:0] DB[4] = '{24'h000100, 24'h000040, 24'h000007, 24'hFFFFFF};
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] rom[4][512];
   logic        start_v[4] = '{0, 0, 0, 0};
   int          mode_v[4] = '{0, 0, 0, 0};
   logic        done_v[4], busy_v[4], hold_v[4], wr_v[4];
   logic [8:0]  pa_v[4];
   logic [23:0] ma_v[4];
   logic [31:0] md_v[4], chk_v[4];
   logic [23:0] la[4][4096];
   logic [31:0] ld[4][4096];
   int          nw[4] = '{0, 0, 0, 0};
   int          ns[4] = '{0, 0, 0, 0};
   int          uns[4] = '{0, 0, 0, 0};
   int          gb[4] = '{0, 0, 0, 0};
   int          n_chk = 0, n_fail = 0;
   always #5 clk = ~clk;
   for (genvar g = 0; g < 4; g++) begin : gi
      boot_copier_if #(.AW(24)) bus();
      boot_copier #(.WORDS(NW[g]), .AW(24), .DST_BASE(DB[g])) dut (.clk(clk), .rst(rst), .bus(bus));
      logic [31:0] pd = '0;
      int          wcnt = 0, dly = 0, gap = 2;
      logic        pw = 1'b0, pwr = 1'b0;
      logic [23:0] pa = '0;
      logic [31:0] pdd = '0;
      // ack mode: 0 = tied high, 1 = random 0..3 wait cycles, 2 = tied low
      assign bus.mem_ack   = mode_v[g] == 0 || (mode_v[g] == 1 && wcnt == dly);
      assign bus.prom_data = pd;
      assign bus.start     = start_v[g];
      assign done_v[g] = bus.done;
      assign busy_v[g] = bus.busy;
      assign hold_v[g] = bus.cpu_hold;
      assign wr_v[g]   = bus.mem_wr;
      assign pa_v[g]   = bus.prom_addr;
      assign ma_v[g]   = bus.mem_addr;
      assign md_v[g]   = bus.mem_wdata;
      assign chk_v[g]  = bus.checksum;
      always @(posedge clk) begin
         pd   <= rom[g][bus.prom_addr];
         wcnt <= (bus.mem_wr && !bus.mem_ack) ? wcnt + 1 : 0;
         if (bus.mem_wr && bus.mem_ack) dly <= int'($urandom_range(0, 3));
      end
      always @(negedge clk) begin
         if (bus.mem_wr && bus.mem_ack) begin
            la[g][nw[g] % 4096] <= bus.mem_addr;
            ld[g][nw[g] % 4096] <= bus.mem_wdata;
            nw[g] <= nw[g] + 1;
         end
         if (bus.mem_wr && !bus.mem_ack) ns[g] <= ns[g] + 1;
         if (pw && bus.mem_wr && (pa != bus.mem_addr || pdd != bus.mem_wdata)) uns[g] <= uns[g] + 1;
         if (bus.mem_wr && !pwr && gap < 2) gb[g] <= gb[g] + 1;
         gap <= bus.mem_wr ? 0 : (gap < 100 ? gap + 1 : gap);
         pw  <= bus.mem_wr && !bus.mem_ack;
         pwr <= bus.mem_wr;
         pa  <= bus.mem_addr;
         pdd <= bus.mem_wdata;
      end
   end
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask
   function automatic logic [31:0] model_sum(input int i, input int n);
      logic [31:0] s;
      s = '0;
      for (int k = 0; k < n; k++) s += rom[i][k];
      return s;
   endfunction
   task automatic check_reset_outputs(input string tag);
      for (int i = 0; i < 4; i++) begin
         chk({tag, "_prom_addr"}, pa_v[i], 0);
         chk({tag, "_mem_addr"}, ma_v[i], 0);
         chk({tag, "_mem_wdata"}, md_v[i], 0);
         chk({tag, "_mem_wr"}, wr_v[i], 0);
         chk({tag, "_busy"}, busy_v[i], 0);
         chk({tag, "_done"}, done_v[i], 0);
         chk({tag, "_cpu_hold"}, hold_v[i], 1);
         chk({tag, "_checksum"}, chk_v[i], 0);
      end
   endtask
   // pulse start, then count edges after the start edge until done; optional extra start at cycle 'extra'
   task automatic copy(input int i, input int extra, output int cyc);
      int budget;
      budget = 15 * NW[i] + 50;
      @(negedge clk); start_v[i] = 1'b1;
      @(negedge clk); start_v[i] = 1'b0;
      cyc = 0;
      chk("start_cpu_hold", hold_v[i], 1);
      chk("start_done", done_v[i], 0);
      chk("start_checksum", chk_v[i], 0);
      chk("start_busy", busy_v[i], 1);
      chk("start_prom_addr", pa_v[i], 0);
      while (!done_v[i] && cyc < budget) begin
         @(negedge clk);
         cyc++;
         start_v[i] = cyc == extra;
         if (cyc == extra) chk("extra_start_in_latch", {pa_v[i], wr_v[i], busy_v[i]}, {9'd5, 1'b0, 1'b1});
      end
      @(negedge clk);
      start_v[i] = 1'b0;
      chk("done_within_budget", done_v[i], 1);
   endtask
   task automatic verify(input int i, input int base, input int n, input int cyc, input int s0);
      chk("write_count", nw[i] - base, n);
      for (int k = 0; k < n && k < nw[i] - base; k++) begin
         chk("write_addr", la[i][(base + k) % 4096], 24'(DB[i] + 24'(k)));
         chk("write_data", ld[i][(base + k) % 4096], rom[i][k]);
      end
      chk("copy_cycles", cyc, 3 * n + (ns[i] - s0));
      chk("checksum", chk_v[i], model_sum(i, n));
      chk("done_high", done_v[i], 1);
      chk("cpu_hold_low", hold_v[i], 0);
      chk("busy_low", busy_v[i], 0);
   endtask
   typedef struct {
      int          inst;
      int          mode;
      int          n;
      logic [23:0] first_a;
      logic [23:0] last_a;
   } vec_t;
   vec_t tbl[5];
   initial begin
      int i, base, s0, cyc, cnt;
      tbl[0] = '{0, 0, 512, 24'h000100, 24'h0002FF};
      tbl[1] = '{1, 1, 4, 24'h000040, 24'h000043};
      tbl[2] = '{2, 0, 1, 24'h000007, 24'h000007};
      tbl[3] = '{3, 0, 2, 24'hFFFFFF, 24'h000000};
      tbl[4] = '{1, 1, 4, 24'h000040, 24'h000043};
      for (int r = 0; r < 4; r++)
         for (int k = 0; k < 512; k++) rom[r][k] = r == 0 ? 32'hA5000000 + 32'(k) : $urandom;
      repeat (3) @(negedge clk);
      check_reset_outputs("in_reset");
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check_reset_outputs("idle");
      #2 rst = 1'b1;
      #1 check_reset_outputs("mid_sim_reset");
      @(negedge clk) rst = 1'b0;
      repeat (10) @(negedge clk);
      check_reset_outputs("idle_after_reset");
      for (int v = 0; v < 5; v++) begin
         i = tbl[v].inst;
         mode_v[i] = tbl[v].mode;
         base = nw[i];
         s0 = ns[i];
         copy(i, -1, cyc);
         chk("first_addr", la[i][base % 4096], tbl[v].first_a);
         chk("last_addr", la[i][(base + tbl[v].n - 1) % 4096], tbl[v].last_a);
         verify(i, base, tbl[v].n, cyc, s0);
         repeat (5) @(negedge clk);
         chk("done_sticky", {done_v[i], hold_v[i], wr_v[i]}, {1'b1, 1'b0, 1'b0});
      end
      chk("full_copy_1536_cycles", 3 * tbl[0].n, 1536);
      // abort during the write of word 100 while memory withholds ack
      mode_v[0] = 0;
      @(negedge clk); start_v[0] = 1'b1;
      @(negedge clk); start_v[0] = 1'b0;
      cnt = 0;
      while (pa_v[0] != 9'd100 && cnt < 2000) begin @(negedge clk); cnt++; end
      mode_v[0] = 2;
      while (!wr_v[0] && cnt < 2000) begin @(negedge clk); cnt++; end
      chk("reach_word100_write", {pa_v[0], wr_v[0]}, {9'd100, 1'b1});
      chk("partial_checksum", chk_v[0], model_sum(0, 101));
      repeat (2) @(negedge clk);
      chk("stall_mem_addr", ma_v[0], 24'h000100 + 24'd100);
      #2 rst = 1'b1;
      #1 chk("abort_mem_wr_async", wr_v[0], 0);
      check_reset_outputs("abort");
      @(negedge clk) rst = 1'b0;
      mode_v[0] = 0;
      base = nw[0];
      s0 = ns[0];
      copy(0, -1, cyc);
      verify(0, base, 512, cyc, s0);
      // extra start during LATCH of word 5 is ignored
      base = nw[0];
      s0 = ns[0];
      copy(0, 16, cyc);
      verify(0, base, 512, cyc, s0);
      // restart from DONE repeats an identical copy
      base = nw[0];
      s0 = ns[0];
      copy(0, -1, cyc);
      verify(0, base, 512, cyc, s0);
      for (int k = 0; k < 512; k++) begin
         chk("repeat_identical_addr", la[0][(base + k) % 4096], la[0][(base - 512 + k) % 4096]);
         chk("repeat_identical_data", ld[0][(base + k) % 4096], ld[0][(base - 512 + k) % 4096]);
      end
      for (int r = 0; r < 4; r++) begin
         chk("stall_stability", uns[r], 0);
         chk("write_spacing", gb[r], 0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
